// File: rtl/wifi_rx_demapper_qpsk_if.sv
// Sample-in / bit-out handshake bundle for the QPSK hard-decision demapper.
interface wifi_rx_demapper_qpsk_if;
   logic        valid_in;
   logic [11:0] data_in_real;
   logic [11:0] data_in_imag;
   logic        in_ready;
   logic        valid_out;
   logic        data_out;
   logic        out_ready;

   // Upstream equalizer and downstream deinterleaver side.
   modport master (
      output valid_in,
      output data_in_real,
      output data_in_imag,
      output out_ready,
      input  in_ready,
      input  valid_out,
      input  data_out
   );

   // Demapper side.
   modport slave (
      input  valid_in,
      input  data_in_real,
      input  data_in_imag,
      input  out_ready,
      output in_ready,
      output valid_out,
      output data_out
   );
endinterface

// File: rtl/wifi_rx_demapper_qpsk.sv
// QPSK hard-decision demapper: slices I/Q signs into {b1,b0}, buffers the
// decisions in a small symbol FIFO and serializes them MSB-first onto a
// 1-bit valid/ready stream. Also counts low-confidence symbols and flags
// input samples dropped while the FIFO was full.
module wifi_rx_demapper_qpsk #(
   parameter logic [11:0] THRESH = 12'd181,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   wifi_rx_demapper_qpsk_if.slave       bus,
   input  logic                         clr_stat,
   output logic [15:0]                  weak_cnt,
   output logic                         drop_flag
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned MAG_W = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BIT1 = 2'd1,
      ST_BIT0 = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Decision and confidence
   // ------------------------------------------------------------------
   logic [1:0]       sym_in;
   logic [MAG_W-1:0] mag_i;
   logic [MAG_W-1:0] mag_q;
   logic [MAG_W-1:0] thresh_ext;
   logic             weak_in;

   // Sign slice (zero decides as 1) and 13-bit magnitudes so -2048 stays 2048.
   always_comb begin
      sym_in     = {~bus.data_in_real[11], ~bus.data_in_imag[11]};
      mag_i      = bus.data_in_real[11] ? MAG_W'(MAG_W'(0) - {1'b1, bus.data_in_real})
                                        : {1'b0, bus.data_in_real};
      mag_q      = bus.data_in_imag[11] ? MAG_W'(MAG_W'(0) - {1'b1, bus.data_in_imag})
                                        : {1'b0, bus.data_in_imag};
      thresh_ext = {1'b0, THRESH};
      weak_in    = (mag_i < thresh_ext) || (mag_q < thresh_ext);
   end

   // ------------------------------------------------------------------
   // Symbol FIFO
   // ------------------------------------------------------------------
   logic [1:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             fifo_empty;
   logic             in_ready_c;
   logic             push;
   logic             pop;
   logic [1:0]       rd_sym;

   // Full/empty status and the accept strobe; no bypass when full.
   always_comb begin
      fifo_empty = (count_q == '0);
      in_ready_c = (count_q != CNT_W'(DEPTH));
      push       = bus.valid_in & in_ready_c;
      rd_sym     = mem[rd_ptr_q];
   end

   assign bus.in_ready = in_ready_c;

   // Storage array; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= sym_in;
      end
   end

   // Circular pointers and occupancy count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
         end
         if (pop) begin
            rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
         end
         case ({push, pop})
            2'b10:   count_q <= CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_q <= CNT_W'(count_q - CNT_W'(1));
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Serializer FSM
   // ------------------------------------------------------------------
   state_t state_q;
   state_t state_d;
   logic   valid_out_q;
   logic   valid_out_d;
   logic   data_out_q;
   logic   data_out_d;
   logic   b0_q;
   logic   b0_d;

   // State and registered stream outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         valid_out_q <= 1'b0;
         data_out_q  <= 1'b0;
         b0_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         b0_q        <= b0_d;
      end
   end

   // Next state: b1 on load, b0 after the first handshake, reload back-to-back.
   always_comb begin
      state_d     = state_q;
      valid_out_d = valid_out_q;
      data_out_d  = data_out_q;
      b0_d        = b0_q;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            valid_out_d = 1'b0;
            if (!fifo_empty) begin
               pop         = 1'b1;
               data_out_d  = rd_sym[1];
               b0_d        = rd_sym[0];
               valid_out_d = 1'b1;
               state_d     = ST_BIT1;
            end
         end
         ST_BIT1: begin
            if (bus.out_ready) begin
               data_out_d = b0_q;
               state_d    = ST_BIT0;
            end
         end
         ST_BIT0: begin
            if (bus.out_ready) begin
               if (!fifo_empty) begin
                  pop         = 1'b1;
                  data_out_d  = rd_sym[1];
                  b0_d        = rd_sym[0];
                  valid_out_d = 1'b1;
                  state_d     = ST_BIT1;
               end else begin
                  valid_out_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: begin
            valid_out_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   assign bus.valid_out = valid_out_q;
   assign bus.data_out  = data_out_q;

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
   // Saturating weak counter and sticky drop flag; clear wins over updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weak_cnt  <= 16'd0;
         drop_flag <= 1'b0;
      end else if (clr_stat) begin
         weak_cnt  <= 16'd0;
         drop_flag <= 1'b0;
      end else begin
         if (push && weak_in && (weak_cnt != 16'hFFFF)) begin
            weak_cnt <= 16'(weak_cnt + 16'd1);
         end
         if (bus.valid_in && !in_ready_c) begin
            drop_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wifi_rx_demapper_qpsk.sv
// Scoreboard bench for the QPSK demapper: the driver queues expected bits
// for every accepted sample, an independent monitor checks the serial stream.
module tb_wifi_rx_demapper_qpsk;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr_stat;
   logic [15:0] weak_cnt;
   logic        drop_flag;

   wifi_rx_demapper_qpsk_if bus ();

   wifi_rx_demapper_qpsk dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .clr_stat  (clr_stat),
      .weak_cnt  (weak_cnt),
      .drop_flag (drop_flag)
   );

   always #5 clk = ~clk;

   int n_vec     = 0;
   int n_err     = 0;
   int bits_seen = 0;
   bit exp_q[$];
   bit mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every completed output handshake is checked against the queue.
   always @(negedge clk) begin
      if (!reset && bus.valid_out && bus.out_ready) begin
         bits_seen++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_extra: got bit %0b, expected no output at %0t", bus.data_out, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("stream_bit", 32'(bus.data_out), 32'(mon_exp));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle sample; expected symbol is queued only if the DUT accepts it.
   task automatic send(input logic signed [11:0] i, input logic signed [11:0] q,
                       input logic [1:0] exp_sym);
      bus.valid_in     = 1'b1;
      bus.data_in_real = i;
      bus.data_in_imag = q;
      if (bus.in_ready) begin
         exp_q.push_back(exp_sym[1]);
         exp_q.push_back(exp_sym[0]);
      end
      tick(1);
      bus.valid_in = 1'b0;
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (exp_q.size() == 0 && !bus.valid_out) begin
            done = 1'b1;
            break;
         end
         tick(1);
      end
      check(name, 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   int b_start;

   initial begin
      reset            = 1'b1;
      clr_stat         = 1'b0;
      bus.valid_in     = 1'b0;
      bus.data_in_real = '0;
      bus.data_in_imag = '0;
      bus.out_ready    = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);

      // Reset state
      check("rst_valid_out", 32'(bus.valid_out), 32'd0);
      check("rst_data_out",  32'(bus.data_out),  32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_weak_cnt",  32'(weak_cnt),      32'd0);
      check("rst_drop_flag", 32'(drop_flag),     32'd0);

      // Four constellation corners, stream 00 01 10 11
      bus.out_ready = 1'b1;
      send(-12'sd362, -12'sd362, 2'b00); tick(1);
      send(-12'sd362,  12'sd362, 2'b01); tick(1);
      send( 12'sd362, -12'sd362, 2'b10); tick(1);
      send( 12'sd362,  12'sd362, 2'b11); tick(1);
      drain("corners_drain");
      check("corners_weak_cnt",  32'(weak_cnt),  32'd0);
      check("corners_drop_flag", 32'(drop_flag), 32'd0);

      // Single-sample latency
      tick(2);
      send(12'sd362, -12'sd362, 2'b10);
      check("lat_k_valid",   32'(bus.valid_out), 32'd0);
      tick(1);
      check("lat_k1_valid",  32'(bus.valid_out), 32'd1);
      check("lat_k1_data",   32'(bus.data_out),  32'd1);
      tick(1);
      check("lat_k2_valid",  32'(bus.valid_out), 32'd1);
      check("lat_k2_data",   32'(bus.data_out),  32'd0);
      tick(1);
      check("lat_k3_valid",  32'(bus.valid_out), 32'd0);
      drain("lat_drain");

      // Back-pressure burst: 5 accepted, 6th dropped
      bus.out_ready = 1'b0;
      b_start = bits_seen;
      send( 12'sd362,  12'sd362, 2'b11);
      send(-12'sd362, -12'sd362, 2'b00);
      send( 12'sd362, -12'sd362, 2'b10);
      send(-12'sd362,  12'sd362, 2'b01);
      check("burst_ready_after4", 32'(bus.in_ready), 32'd1);
      send( 12'sd362,  12'sd362, 2'b11);
      check("burst_ready_after5", 32'(bus.in_ready), 32'd0);
      check("burst_drop_before",  32'(drop_flag),    32'd0);
      send(-12'sd362, -12'sd362, 2'b00);
      check("burst_drop_after",   32'(drop_flag),    32'd1);
      for (int s = 0; s < 3; s++) begin
         check("stall_valid", 32'(bus.valid_out), 32'd1);
         check("stall_data",  32'(bus.data_out),  32'd1);
         tick(1);
      end
      bus.out_ready = 1'b1;
      drain("burst_drain");
      check("burst_bit_count", 32'(bits_seen - b_start), 32'd10);

      // Weak detection; 181 itself is not weak
      send( 12'sd100,   12'sd362,  2'b11); tick(1);
      send( 12'sd362,  -12'sd180,  2'b10); tick(1);
      send(-12'sd2048,  12'sd0,    2'b01); tick(1);
      send( 12'sd181,  -12'sd181,  2'b10); tick(1);
      drain("weak_drain");
      check("weak_cnt_3",      32'(weak_cnt),  32'd3);
      check("weak_drop_kept",  32'(drop_flag), 32'd1);
      clr_stat = 1'b1;
      tick(1);
      clr_stat = 1'b0;
      check("clr_weak_cnt",  32'(weak_cnt),  32'd0);
      check("clr_drop_flag", 32'(drop_flag), 32'd0);
      // Clear beats a same-cycle weak accept
      clr_stat = 1'b1;
      send(12'sd100, 12'sd100, 2'b11);
      clr_stat = 1'b0;
      check("clr_priority", 32'(weak_cnt), 32'd0);
      drain("clr_drain");

      // Reset mid-BIT1 with three symbols in the FIFO
      bus.out_ready = 1'b0;
      send(12'sd362, 12'sd362, 2'b11);
      send(12'sd362, 12'sd362, 2'b11);
      send(12'sd362, 12'sd362, 2'b11);
      send(12'sd362, 12'sd362, 2'b11);
      check("pre_rst_valid", 32'(bus.valid_out), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid",    32'(bus.valid_out), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
      exp_q.delete();
      tick(1);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick(1);
         check("post_rst_no_stale", 32'(bus.valid_out), 32'd0);
      end

      // Saturation of the weak counter
      force dut.weak_cnt = 16'hFFFE;
      #1;
      release dut.weak_cnt;
      tick(1);
      send(12'sd100, 12'sd100, 2'b11);
      check("sat_first",  32'(weak_cnt), 32'hFFFF);
      tick(1);
      send(12'sd100, 12'sd100, 2'b11);
      tick(1);
      send(12'sd100, 12'sd100, 2'b11);
      check("sat_hold",   32'(weak_cnt), 32'hFFFF);
      drain("sat_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wifi_rx_demapper_qpsk.md
# wifi_rx_demapper_qpsk

Receive-side QPSK hard-decision demapper for the WIFI PHY. It accepts equalized 12-bit signed I/Q samples, slices each to two bits that invert the TX QPSK mapping, and buffers the decisions in a 4-deep symbol FIFO. It then serializes them MSB-first onto a 1-bit valid/ready stream toward the RX deinterleaver. It also counts low-confidence symbols and flags dropped input.

## Interface
- THRESH, 12'd181: magnitude threshold. A symbol is weak when |I| < THRESH or |Q| < THRESH. The default is half the nominal ±362 constellation point.
- DEPTH, 4: FIFO depth in symbols. Must be a power of two, ≥ 2.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  an I/Q sample is present this cycle.
- data_in_real  input  12  I sample, two's complement.
- data_in_imag  input  12  Q sample, two's complement.
- in_ready  output  1  the block accepts a sample this cycle. Combinational: FIFO count != DEPTH.
- valid_out  output  1  data_out holds a valid bit. Registered.
- data_out  output  1  serial decided bit. Registered.
- out_ready  input  1  downstream accepts data_out this cycle.
- clr_stat  input  1  synchronous clear of weak_cnt and drop_flag.
- weak_cnt  output  16  saturating count of accepted weak symbols.
- drop_flag  output  1  sticky. Set when valid_in=1 while in_ready=0.

## Operation
- Decision, combinational at FIFO write:
  - b1 = ~data_in_real[11], so I ≥ 0 gives 1.
  - b0 = ~data_in_imag[11], so Q ≥ 0 gives 1.
  - Zero decides as 1.
  - The symbol is {b1,b0}. This matches the TX map: 00 means (−,−), 11 means (+,+).
- Accept: valid_in & in_ready pushes {b1,b0} into the FIFO at the clock edge.
- Overflow: valid_in & ~in_ready drops the sample and sets drop_flag. weak_cnt is not updated. The FIFO has no bypass, so a push is refused when full even if a pop occurs in the same cycle.
- Weak detection:
  - Magnitudes are computed at 13 bits, so −2048 has magnitude 2048.
  - Each accepted weak symbol increments weak_cnt, which saturates at 16'hFFFF.
- clr_stat clears weak_cnt and drop_flag. It has priority over a same-cycle increment or set.
- The FIFO is a circular buffer with DEPTH entries and wrapping read/write pointers. The count ranges 0..DEPTH. A simultaneous push and pop leaves the count unchanged.
- Serializer FSM:
  - IDLE: valid_out=0. If the FIFO is not empty, pop, load the symbol, drive data_out=b1 and valid_out=1, then go to BIT1.
  - BIT1: hold data_out until out_ready=1. Then drive data_out=b0 and go to BIT0.
  - BIT0: hold until out_ready=1. Then:
    - If the FIFO is not empty: pop, drive the next b1, go to BIT1. There is no idle gap.
    - Otherwise: valid_out=0, go to IDLE.
- valid_out and data_out must not change while valid_out=1 & out_ready=0.
- Total buffering is DEPTH symbols in the FIFO plus 1 symbol in the serializer.

## Timing
- Reset values: valid_out=0, data_out=0, weak_cnt=0, drop_flag=0, FIFO empty, FSM in IDLE. in_ready therefore reads 1.
- Reset asserted mid-operation discards the FIFO and serializer contents immediately. No partial symbol is emitted after release.
- Latency: a sample accepted at edge k makes b1 visible with valid_out=1 after edge k+1, provided the serializer is IDLE.
- Throughput: at most one symbol per 2 cycles at the output. The input can burst DEPTH+1 symbols before in_ready falls. With out_ready held at 1, input at 1 symbol per 2 cycles runs indefinitely with no drops.
- weak_cnt and drop_flag update at the edge of the causing cycle and are visible the following cycle.

## Test plan
- Reset, then four samples (I,Q) = (−362,−362), (−362,+362), (+362,−362), (+362,+362) spaced 2 cycles apart, out_ready=1. Required: serial stream 0,0,0,1,1,0,1,1; weak_cnt=0; drop_flag=0.
- Single sample (+362,−362) at edge k. Required: valid_out rises after edge k+1 with data_out=1, then data_out=0 the next cycle, then valid_out=0.
- out_ready=0 and 6 consecutive valid_in samples. Required:
  - in_ready falls after 5 accepts (1 in the serializer, 4 in the FIFO).
  - The 6th sample sets drop_flag.
  - data_out holds steady.
  - After releasing out_ready, exactly 10 bits emerge in order.
- Weak samples (100,362), (362,−180), (−2048,0), (181,−181). Required: weak_cnt=3, because 181 is not < 181. Then pulse clr_stat: weak_cnt=0 and drop_flag=0.
- Assert reset mid-BIT1 with 3 symbols buffered. Required: valid_out=0 immediately, in_ready=1, and no stale bits after release. Also force weak_cnt near 16'hFFFF and apply 3 weak symbols: weak_cnt saturates at 16'hFFFF.
